// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-requester SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_pend_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from req and the priority pointer.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output req_id_e    gnt_id,
  output logic       gnt_any
);

  req_id_e rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt_id = REQ_M0;
    case (req)
      2'b01:   gnt_id = REQ_M0;
      2'b10:   gnt_id = REQ_M1;
      2'b11:   gnt_id = rr_ptr_q;
      default: gnt_id = REQ_M0;
    endcase

    gnt_any = (|req) && !rst;
    gnt[0]  = gnt_any && (gnt_id == REQ_M0);
    gnt[1]  = gnt_any && (gnt_id == REQ_M1);

    // Priority passes to the other requester after every grant.
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_id == REQ_M0) ? REQ_M1 : REQ_M0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= REQ_M0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin sharing of one single-port SRAM between M0 and M1, with read-data
// return to the issuing requester and per-requester grant counters.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [CNT_W-1:0]  m0_gnt_cnt,
  output logic [CNT_W-1:0]  m1_gnt_cnt
);

  logic [1:0] gnt;
  req_id_e    gnt_id;
  logic       gnt_any;
  logic       granted_we;

  rd_pend_t             rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0]     m0_cnt_q, m0_cnt_d;
  logic [CNT_W-1:0]     m1_cnt_q, m1_cnt_d;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_req, m0_req}),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // Without a grant the SRAM sees M0's inputs so the bus is never left floating.
  always_comb begin
    sram_addr  = m0_addr;
    sram_wdata = m0_wdata;
    granted_we = m0_we;
    if (gnt[1]) begin
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
      granted_we = m1_we;
    end
    sram_we = gnt_any & granted_we;

    rd_pend_d.valid = gnt_any & ~granted_we;
    rd_pend_d.id    = gnt_id;

    m0_cnt_d = m0_cnt_q + CNT_W'(gnt[0]);
    m1_cnt_d = m1_cnt_q + CNT_W'(gnt[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= '0;
      m0_cnt_q  <= '0;
      m1_cnt_q  <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      m0_cnt_q  <= m0_cnt_d;
      m1_cnt_q  <= m1_cnt_d;
    end
  end

  // A read returning while reset is asserted is discarded.
  always_comb begin
    m0_rvalid = rd_pend_q.valid && (rd_pend_q.id == REQ_M0) && !rst;
    m1_rvalid = rd_pend_q.valid && (rd_pend_q.id == REQ_M1) && !rst;
  end

  assign m0_rdata   = sram_rdata;
  assign m1_rdata   = sram_rdata;
  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign m0_gnt_cnt = m0_cnt_q;
  assign m1_gnt_cnt = m1_cnt_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a behavioural arbitration/SRAM model.
module tb_sram_rr_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [CW-1:0] m0_gnt_cnt, m1_gnt_cnt;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .m0_gnt_cnt (m0_gnt_cnt),
    .m1_gnt_cnt (m1_gnt_cnt)
  );

  // Single-port SRAM with one-cycle registered read.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  function automatic logic [31:0] init_val(int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: who holds priority, what each requester has been granted,
  // the memory contents in grant order, and the one outstanding read.
  int            prio = 0;
  int            cnt_m [2];
  bit            cnt_known = 0;
  bit            pend_v = 0;
  int            pend_id = 0;
  logic [31:0]   pend_data;
  logic [31:0]   mem_m [256];
  int            exp_g;

  task automatic step(input logic r, input logic q0, input logic w0, input logic [7:0] a0,
                      input logic [31:0] d0, input logic q1, input logic w1,
                      input logic [7:0] a1, input logic [31:0] d1);
    logic exp_we;
    @(negedge clk);
    rst = r;
    m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    if (r) exp_g = -1;
    else if (q0 && q1) exp_g = prio;
    else if (q0) exp_g = 0;
    else if (q1) exp_g = 1;
    else exp_g = -1;
    exp_we = (exp_g == 0) ? w0 : (exp_g == 1) ? w1 : 1'b0;

    chk("m0_gnt", 64'(m0_gnt), 64'(exp_g == 0));
    chk("m1_gnt", 64'(m1_gnt), 64'(exp_g == 1));
    chk("sram_we", 64'(sram_we), 64'(exp_we));
    chk("sram_addr", 64'(sram_addr), 64'((exp_g == 1) ? a1 : a0));
    chk("sram_wdata", 64'(sram_wdata), 64'((exp_g == 1) ? d1 : d0));
    chk("m0_rvalid", 64'(m0_rvalid), 64'(!r && pend_v && pend_id == 0));
    chk("m1_rvalid", 64'(m1_rvalid), 64'(!r && pend_v && pend_id == 1));
    if (!r && pend_v) begin
      if (pend_id == 0) chk("m0_rdata", 64'(m0_rdata), 64'(pend_data));
      else chk("m1_rdata", 64'(m1_rdata), 64'(pend_data));
    end
    if (!r && cnt_known) begin
      chk("m0_gnt_cnt", 64'(m0_gnt_cnt), 64'(cnt_m[0]));
      chk("m1_gnt_cnt", 64'(m1_gnt_cnt), 64'(cnt_m[1]));
    end

    if (r) begin
      prio = 0; pend_v = 0; cnt_m[0] = 0; cnt_m[1] = 0; cnt_known = 1;
    end else if (exp_g >= 0) begin
      prio = 1 - exp_g;
      cnt_m[exp_g] = (cnt_m[exp_g] + 1) % (1 << CW);
      pend_v = !exp_we;
      pend_id = exp_g;
      if (exp_g == 0) begin
        if (w0) mem_m[a0] = d0; else pend_data = mem_m[a0];
      end else begin
        if (w1) mem_m[a1] = d1; else pend_data = mem_m[a1];
      end
    end else begin
      pend_v = 0;
    end
  endtask

  typedef struct {
    logic        rst;
    logic        q0, w0;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic        q1, w1;
    logic [7:0]  a1;
    logic [31:0] d1;
    logic        g0, g1, v0, v1;
    logic [31:0] rd;
    bit          ck_cnt;
    int          c0, c1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic q0, logic w0, logic [7:0] a0, logic [31:0] d0,
                              logic q1, logic w1, logic [7:0] a1, logic [31:0] d1,
                              logic g0, logic g1, logic v0, logic v1, logic [31:0] rd,
                              bit ck = 0, int c0 = 0, int c1 = 0);
    vec_t v;
    v.rst = r; v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
    v.ck_cnt = ck; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        hq [2];
    logic        hw [2];
    logic [7:0]  ha [2];
    logic [31:0] hd [2];
    bit          hold [2];

    for (int i = 0; i < 256; i++) begin
      mem[i]   = init_val(i);
      mem_m[i] = init_val(i);
    end
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;

    // Reset with both requesting, then first grant goes to M0
    for (int i = 0; i < 3; i++) vq.push_back(mk(1, 1,0,8'h30,0, 1,0,8'h31,0, 0,0,0,0, 0));
    vq.push_back(mk(0, 1,0,8'h30,0, 1,0,8'h31,0, 1,0,0,0, 0));
    vq.push_back(mk(0, 0,0,8'h00,0, 1,0,8'h31,0, 0,1,1,0, init_val(8'h30)));
    vq.push_back(mk(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,1, init_val(8'h31)));
    // Solo M0 write then read-back
    vq.push_back(mk(0, 1,1,8'h10,32'hDEADBEEF, 0,0,8'h00,0, 1,0,0,0, 0));
    vq.push_back(mk(0, 1,0,8'h10,0, 0,0,8'h00,0, 1,0,0,0, 0));
    vq.push_back(mk(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,1,0, 32'hDEADBEEF));
    // Contention: 8 cycles of reads from both after a reset
    vq.push_back(mk(1, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0));
    for (int i = 0; i < 8; i++) begin
      vq.push_back(mk(0, 1,0,8'h40,0, 1,0,8'h41,0, (i % 2) == 0, (i % 2) == 1,
                      (i % 2) == 1, (i > 0) && (i % 2) == 0,
                      (i % 2) == 1 ? init_val(8'h40) : init_val(8'h41)));
    end
    vq.push_back(mk(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,1, init_val(8'h41), 1, 4, 4));
    // Same-cycle write/read of 0x20: M0 holds priority so the read sees 0x55
    vq.push_back(mk(0, 1,1,8'h20,32'h55, 1,0,8'h20,0, 1,0,0,0, 0));
    vq.push_back(mk(0, 0,0,8'h00,0, 1,0,8'h20,0, 0,1,0,0, 0));
    vq.push_back(mk(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,1, 32'h55));
    // Reset arriving in the return cycle of an M1 read
    vq.push_back(mk(0, 0,0,8'h00,0, 1,0,8'h22,0, 0,1,0,0, 0));
    vq.push_back(mk(1, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0));
    vq.push_back(mk(0, 1,0,8'h23,0, 1,0,8'h24,0, 1,0,0,0, 0));
    vq.push_back(mk(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,1,0, init_val(8'h23)));

    foreach (vq[k]) begin
      step(vq[k].rst, vq[k].q0, vq[k].w0, vq[k].a0, vq[k].d0,
           vq[k].q1, vq[k].w1, vq[k].a1, vq[k].d1);
      chk($sformatf("tbl%0d_g0", k), 64'(m0_gnt), 64'(vq[k].g0));
      chk($sformatf("tbl%0d_g1", k), 64'(m1_gnt), 64'(vq[k].g1));
      chk($sformatf("tbl%0d_v0", k), 64'(m0_rvalid), 64'(vq[k].v0));
      chk($sformatf("tbl%0d_v1", k), 64'(m1_rvalid), 64'(vq[k].v1));
      if (vq[k].v0) chk($sformatf("tbl%0d_rd0", k), 64'(m0_rdata), 64'(vq[k].rd));
      if (vq[k].v1) chk($sformatf("tbl%0d_rd1", k), 64'(m1_rdata), 64'(vq[k].rd));
      if (vq[k].ck_cnt) begin
        chk("tbl_cnt0", 64'(m0_gnt_cnt), 64'(vq[k].c0));
        chk("tbl_cnt1", 64'(m1_gnt_cnt), 64'(vq[k].c1));
      end
    end

    // Counter wrap: 17 M1 grants on a 4-bit counter leave 1
    step(1, 0,0,8'h00,0, 0,0,8'h00,0);
    for (int i = 0; i < 17; i++) step(0, 0,0,8'h00,0, 1,0,8'h05,0);
    step(0, 0,0,8'h00,0, 0,0,8'h00,0);
    chk("cnt_wrap_m1", 64'(m1_gnt_cnt), 64'd1);
    chk("cnt_wrap_m0", 64'(m0_gnt_cnt), 64'd0);

    // Random traffic; a requester keeps its access stable until granted or abandoned
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 500; c++) begin
      logic r;
      for (int m = 0; m < 2; m++) begin
        if (hold[m] && $urandom_range(0, 15) != 0) continue;
        hq[m] = ($urandom_range(0, 3) != 0);
        hw[m] = $urandom_range(0, 1) == 1;
        ha[m] = 8'($urandom_range(0, 7));
        hd[m] = $urandom;
      end
      r = ($urandom_range(0, 39) == 0);
      step(r, hq[0], hw[0], ha[0], hd[0], hq[1], hw[1], ha[1], hd[1]);
      for (int m = 0; m < 2; m++) hold[m] = hq[m] && (exp_g != m);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
